// File: rtl/cache_controller.sv
// Two-way set-associative, write-through read cache sitting between the MEM
// stage and the SRAM controller. Read hits are answered in the request cycle;
// read misses and every write go out to SRAM with a one-cycle start pulse, and
// the pipeline is held off with `ready` until the SRAM controller finishes.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int SETS = 64;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

  state_e state_q;

  // Line storage: valid and LRU need reset, tags and data do not.
  logic [SETS-1:0] valid0_q, valid1_q;
  logic [SETS-1:0] lru_q;
  logic [10:0]     tag0_q  [SETS];
  logic [10:0]     tag1_q  [SETS];
  logic [31:0]     data0_q [SETS];
  logic [31:0]     data1_q [SETS];

  logic [5:0]  idx;
  logic [10:0] tag;
  logic        hit0, hit1, hit;
  logic        hit_way, victim;
  logic        is_idle;
  logic        wr_issue, rd_hit, rd_miss;
  logic        rd_fill, wr_done;

  assign idx = address[7:2];
  assign tag = address[18:8];

  assign hit0    = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1    = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit     = hit0 || hit1;
  // Both ways can never hold the same tag (fills only happen on a miss),
  // so way 0 winning a tie is only a formality.
  assign hit_way = !hit0;

  // Invalid ways are filled first, lowest way first; otherwise follow LRU.
  assign victim = !valid0_q[idx] ? 1'b0 :
                  !valid1_q[idx] ? 1'b1 : lru_q[idx];

  assign is_idle  = (state_q == IDLE);
  assign wr_issue = is_idle && mem_w_en;
  assign rd_hit   = is_idle && !mem_w_en && mem_r_en && hit;
  assign rd_miss  = is_idle && !mem_w_en && mem_r_en && !hit;
  assign rd_fill  = (state_q == RD_WAIT) && sram_ready;
  assign wr_done  = (state_q == WR_WAIT) && sram_ready;

  // SRAM side: start pulses only leave IDLE, address/data pass straight through.
  assign sram_rd_en   = rd_miss;
  assign sram_wr_en   = wr_issue;
  assign sram_address = address;
  assign sram_wdata   = wdata;

  // Pipeline handshake and read data, including the fill-cycle bypass.
  always_comb begin
    ready = 1'b1;
    rdata = 32'h0;
    unique case (state_q)
      IDLE: begin
        ready = !(wr_issue || rd_miss);
        if (hit) rdata = hit_way ? data1_q[idx] : data0_q[idx];
      end
      RD_WAIT: begin
        ready = sram_ready;
        if (sram_ready) rdata = sram_rdata;
      end
      WR_WAIT: ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

  // Controller state: issue from IDLE, wait for the SRAM controller to finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_issue)     state_q <= WR_WAIT;
          else if (rd_miss) state_q <= RD_WAIT;
        end
        RD_WAIT: if (sram_ready) state_q <= IDLE;
        WR_WAIT: if (sram_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid and LRU bookkeeping: fills mark the victim valid, any touch of a
  // way (hit read, hit write, fill) makes the other way the next victim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (rd_fill) begin
        if (victim) valid1_q[idx] <= 1'b1;
        else        valid0_q[idx] <= 1'b1;
        lru_q[idx] <= !victim;
      end else if (rd_hit || (wr_issue && hit)) begin
        lru_q[idx] <= !hit_way;
      end
    end
  end

  // Tag/data arrays: fill the victim on read completion, update in place on
  // a write hit (write-through, no allocate on write miss).
  always_ff @(posedge clk) begin
    if (rd_fill) begin
      if (victim) begin
        tag1_q[idx]  <= tag;
        data1_q[idx] <= sram_rdata;
      end else begin
        tag0_q[idx]  <= tag;
        data0_q[idx] <= sram_rdata;
      end
    end else if (wr_issue && hit) begin
      if (hit_way) data1_q[idx] <= wdata;
      else         data0_q[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural SRAM controller, an LRU-list
// reference model per set, and a scoreboard drained by a separate monitor.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [16:0] k);
    return {k[15:0], ~k[15:0]} ^ 32'h5A5A_1234;
  endfunction

  // ---------------- SRAM controller model ----------------
  // Reads: busy R1..R6, ready again in R6. Writes: busy W1..W5, ready in W5.
  logic [31:0] smem [logic [16:0]];
  logic        s_busy = 1'b0;
  int          s_cnt  = 0;
  logic [31:0] s_rd_q = '0;

  assign sram_ready = !s_busy || (s_cnt == 1);
  assign sram_rdata = (s_busy && s_cnt == 1) ? s_rd_q : 32'hBAD0_BAD0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      s_busy <= 1'b0;
      s_cnt  <= 0;
    end else if (!s_busy && (sram_rd_en || sram_wr_en)) begin
      s_busy <= 1'b1;
      s_cnt  <= sram_rd_en ? 6 : 5;
      if (sram_wr_en) smem[sram_address[18:2]] = sram_wdata;
      else s_rd_q <= smem.exists(sram_address[18:2]) ? smem[sram_address[18:2]]
                                                      : dflt(sram_address[18:2]);
    end else if (s_busy) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) s_busy <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Each set is a recency list of at most two resident tags (MRU first).
  logic [31:0] rmem [logic [16:0]];
  int          r_cnt [64];
  logic [10:0] r_mru [64];
  logic [10:0] r_lru [64];

  function automatic logic [31:0] rmem_rd(input logic [16:0] k);
    return rmem.exists(k) ? rmem[k] : dflt(k);
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 64; i++) r_cnt[i] = 0;
  endfunction

  function automatic bit model_lookup_touch(input int s, input logic [10:0] t);
    if (r_cnt[s] >= 1 && r_mru[s] == t) return 1'b1;
    if (r_cnt[s] == 2 && r_lru[s] == t) begin
      r_lru[s] = r_mru[s];
      r_mru[s] = t;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_fill(input int s, input logic [10:0] t);
    if (r_cnt[s] > 0) r_lru[s] = r_mru[s];
    r_mru[s] = t;
    if (r_cnt[s] < 2) r_cnt[s]++;
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    int          cycles;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sb[$];
  bit   sb_on = 1'b0;

  initial begin
    int cyc, nrd, nwr;
    exp_t e;
    cyc = 0; nrd = 0; nwr = 0;
    forever begin
      @(negedge clk);
      if (rst || !sb_on || !(mem_r_en || mem_w_en)) begin
        cyc = 0; nrd = 0; nwr = 0;
      end else begin
        cyc++;
        nrd += int'(sram_rd_en);
        nwr += int'(sram_wr_en);
        if (ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.cycles);
            chk("rd_pulses", nrd, e.nrd);
            chk("wr_pulses", nwr, e.nwr);
            if (e.is_rd) chk("rdata", rdata, e.rdata);
          end
          cyc = 0; nrd = 0; nwr = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   s;
    bit   h;
    int   n;
    s = int'(a[7:2]);
    h = model_lookup_touch(s, a[18:8]);
    e.is_rd = r && !w;
    e.rdata = '0;
    if (w) begin
      e.cycles = 6; e.nrd = 0; e.nwr = 1;
      rmem[a[18:2]] = d;
    end else begin
      e.nwr = 0;
      e.rdata = rmem_rd(a[18:2]);
      if (h) begin
        e.cycles = 1; e.nrd = 0;
      end else begin
        e.cycles = 7; e.nrd = 1;
        model_fill(s, a[18:8]);
      end
    end
    sb.push_back(e);
    mem_r_en = r; mem_w_en = w; address = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) begin
      chk("timeout_ready", 32'd0, 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[18:8] = 11'($urandom_range(0, 3));
    a[7:2]  = 6'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    logic [31:0] a;
    model_flush();
    smem[17'h40] = 32'hDEAD_BEEF;
    rmem[17'h40] = 32'hDEAD_BEEF;

    // Reset state with no request presented.
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rd_en", sram_rd_en, 1'b0);
    chk("rst_wr_en", sram_wr_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_on = 1'b1;
    @(posedge clk); #1;

    // Directed sequence: miss/hit, LRU eviction, write hit/miss, dual enable.
    req(1, 0, 32'h0000_0100, '0);
    req(1, 0, 32'h0000_0100, '0);
    req(1, 0, 32'h0000_0200, '0);
    req(1, 0, 32'h0000_0300, '0);
    req(1, 0, 32'h0000_0200, '0);
    req(1, 0, 32'h0000_0100, '0);
    req(0, 1, 32'h0000_0100, 32'h1234_5678);
    req(1, 0, 32'h0000_0100, '0);
    req(0, 1, 32'h0000_0400, 32'hCAFE_F00D);
    req(1, 0, 32'h0000_0400, '0);
    req(1, 1, 32'h0000_0300, 32'h0BAD_CAFE);
    req(1, 0, 32'h0000_0300, '0);
    req(1, 0, 32'hFFF8_0103, '0);

    // Randomized traffic over a small footprint so hits and evictions occur.
    for (int i = 0; i < 300; i++) begin
      a = rand_addr();
      case ($urandom_range(0, 3))
        0:       req(0, 1, a, $urandom);
        1:       req(1, 1, a, $urandom);
        default: req(1, 0, a, '0);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a read miss drops the fill and invalidates lines.
    req(1, 0, 32'h0000_0100, '0);
    sb_on = 1'b0;
    a = {13'h0, 11'h7FF, 6'd5, 2'b00};
    mem_r_en = 1'b1; address = a;
    @(negedge clk);
    chk("midrst_issue_pulse", sram_rd_en, 1'b1);
    chk("midrst_issue_ready", ready, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mem_r_en = 1'b0;
    @(negedge clk);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_rd_en", sram_rd_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_flush();
    sb_on = 1'b1;
    @(posedge clk); #1;
    req(1, 0, a, '0);
    req(1, 0, 32'h0000_0100, '0);
    req(1, 0, 32'h0000_0100, '0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through read cache between the MEM pipeline stage and the SRAM controller. It serves read hits combinationally in the request cycle. Read misses and all writes are forwarded to the SRAM controller through a one-cycle enable pulse and a wait-for-ready handshake. While a miss or write is in flight, the pipeline is held via `ready`.

## Interface
- No parameters. Geometry is fixed: 64 sets, 2 ways, 1-word (32-bit) lines, 11-bit tag.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `mem_r_en`  in  1  pipeline read request; held stable until `ready`
- `mem_w_en`  in  1  pipeline write request; held stable until `ready`
- `address`  in  32  byte address; bits [18:2] are used, bits [1:0] and [31:19] are ignored
- `wdata`  in  32  pipeline write data
- `rdata`  out  32  read data; valid only when `ready`=1 with `mem_r_en`=1
- `ready`  out  1  0 freezes the pipeline
- `sram_rd_en`  out  1  one-cycle read start pulse to the SRAM controller
- `sram_wr_en`  out  1  one-cycle write start pulse to the SRAM controller
- `sram_address`  out  32  equals `address`
- `sram_wdata`  out  32  equals `wdata`
- `sram_rdata`  in  32  SRAM read data; valid when `sram_ready`=1 at the end of a read
- `sram_ready`  in  1  SRAM controller ready; high while idle and in its final op cycle

## Operation
- Address split: `index` = address[7:2], `tag` = address[18:8].
- Storage per set and way: `valid`, `tag[10:0]`, `data[31:0]`.
- Storage per set: one `lru` bit, naming the way to replace next.
- Hit in way w: `valid[w]` is set and `tag[w]` equals `tag`.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE behaviour:
  - `mem_w_en`=1 (has priority over `mem_r_en`):
    - Pulse `sram_wr_en`, go to WR_WAIT.
    - On a hit, write `wdata` into the hit way's data and set `lru` to the other way.
    - On a miss, no allocate and no LRU change.
  - `mem_r_en`=1 and hit:
    - `rdata` = hit way's data, `ready`=1.
    - Set `lru` to the other way. Stay in IDLE.
  - `mem_r_en`=1 and miss: pulse `sram_rd_en`, go to RD_WAIT.
  - No request: `ready`=1, no state change.
- RD_WAIT:
  - Both enables 0, `ready`=0 until `sram_ready`=1.
  - In that cycle, `ready`=1 and `rdata`=`sram_rdata` (combinational bypass).
  - Fill the victim way with valid=1, `tag`, and `sram_rdata`.
  - Set `lru` to the way not filled. Return to IDLE.
- Victim selection: way 0 if invalid, else way 1 if invalid, else the way named by `lru`.
- WR_WAIT: both enables 0, `ready`=0 until `sram_ready`=1. In that cycle `ready`=1, return to IDLE.
- `sram_rd_en` and `sram_wr_en` are never high together, and never high outside IDLE.
- `ready` is combinational.
- Reset state:
  - State IDLE.
  - All `valid` and `lru` bits cleared; data and tag arrays need no reset.
  - `sram_rd_en`=`sram_wr_en`=0.
  - `ready`=1 unless a read miss or write is presented.
  - `rdata`=0 when no hit.

## Timing
- Read hit: 0 extra cycles; `ready`=1 in the request cycle.
- Read miss: the enable pulse is at cycle 0 and the SRAM controller runs R1..R6 in cycles 1-6. `sram_ready` returns at cycle 6, so `ready`=1 and data is returned at cycle 6 (7 cycles total).
- Write, hit or miss: the pulse is at cycle 0 and the SRAM controller runs W1..W5. `ready`=1 at cycle 5 (6 cycles total).
- `sram_ready` is ignored in IDLE and in the issue cycle. It is sampled only in RD_WAIT and WR_WAIT, which start one cycle after issue, when the SRAM controller already reports busy.
- Back-to-back requests: the cycle after a completion is IDLE and can accept a new request.
- Reset mid-operation: state goes immediately to IDLE and valid bits clear. The SRAM controller shares `rst`; the pending fill is dropped.
- Line update and LRU update happen at the clock edge ending the hit or completion cycle.

## Test plan
- After reset, read 0x0000_0100: miss, one `sram_rd_en` pulse, `ready`=0 for cycles 0-5, then at cycle 6 `ready`=1 and `rdata`=SRAM value 0xDEAD_BEEF. Re-read the same address: hit, `ready`=1 same cycle, `rdata`=0xDEAD_BEEF, no SRAM pulse.
- Fill 0x100, then 0x200 and 0x300 (all index 0): 0x100 goes to way 0 and 0x200 to way 1. Reading 0x300 evicts way 0, the LRU way (0x100). Re-reading 0x100 misses; re-reading 0x200 hits.
- Write 0x1234_5678 to cached 0x100: `sram_wr_en` pulse, `ready` high at cycle 5. A subsequent read of 0x100 hits with 0x1234_5678.
- Write to uncached 0x400: SRAM write issued, no allocation. A subsequent read of 0x400 misses.
- `mem_r_en`=`mem_w_en`=1 together: only `sram_wr_en` pulses, and the write path is taken.
- Assert `rst` at cycle 3 of a read miss: state IDLE, `ready`=1, all lines invalid. The next read of the same address misses.
